// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared widths, instruction field positions and fetch FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int c_pc_width    = 16;
    localparam int c_instr_width = 16;

    localparam int c_op_msb    = 15;
    localparam int c_op_lsb    = 12;
    localparam int c_funct_msb = 2;
    localparam int c_funct_lsb = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Request/acknowledge bus between the fetch stage and imem.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_WIDTH    = c_pc_width,
    parameter int INSTR_WIDTH = c_instr_width
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage: PC, imem req/ack handshake, one-entry instr slot.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_WIDTH    = c_pc_width,
    parameter int              INSTR_WIDTH = c_instr_width,
    parameter logic [15:0]     RESET_PC    = 16'h0000,
    parameter int              PC_STEP     = 2
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    instr_fetch_if.master               imem,
    input  wire logic                   stall,
    input  wire logic                   redirect,
    input  wire logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [INSTR_WIDTH-1:0]      instr,
    output logic                        instr_valid,
    output logic [PC_WIDTH-1:0]         pc_out,
    output logic [PC_WIDTH-1:0]         pcplus2,
    output logic [3:0]                  op,
    output logic [2:0]                  funct
);

    localparam logic [PC_WIDTH-1:0] c_step     = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] c_reset_pc = PC_WIDTH'(RESET_PC);

    state_t                  r_state;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [PC_WIDTH-1:0]     r_req_addr;
    logic [PC_WIDTH-1:0]     r_pc_out;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic                    r_instr_valid;

    logic                    w_slot_free;
    logic                    w_req;
    logic [PC_WIDTH-1:0]     w_addr;
    logic                    w_ack;
    logic [PC_WIDTH-1:0]     w_redir_pc;
    logic [PC_WIDTH-1:0]     w_fill_pc;
    logic                    w_fill;

    assign w_slot_free = !r_instr_valid || !stall;
    assign w_redir_pc  = redirect_pc & ~PC_WIDTH'(1);

    always_comb begin
        w_req     = 1'b0;
        w_addr    = r_pc;
        w_fill_pc = r_pc;
        case (r_state)
            ST_FETCH: begin
                w_req = w_slot_free;
            end
            ST_WAIT, ST_DRAIN: begin
                w_req     = 1'b1;
                w_addr    = r_req_addr;
                w_fill_pc = r_req_addr;
            end
            default: ;
        endcase
        // A request in flight is dropped the moment reset is asserted.
        if (!reset_n) begin
            w_req = 1'b0;
        end
    end

    assign w_ack  = w_req && imem.imem_ack;
    assign w_fill = w_ack && !redirect && (r_state != ST_DRAIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= c_reset_pc;
            r_req_addr    <= c_reset_pc;
            r_pc_out      <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (r_instr_valid && !stall) begin
                r_instr_valid <= 1'b0;
            end

            if (w_fill) begin
                r_instr       <= imem.imem_rdata;
                r_pc_out      <= w_fill_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= w_fill_pc + c_step;
            end

            case (r_state)
                ST_FETCH: begin
                    if (w_req) begin
                        r_req_addr <= r_pc;
                        if (!w_ack) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT, ST_DRAIN: begin
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase

            // Redirect wins over any fill; an unanswered request must be drained.
            if (redirect) begin
                r_pc          <= w_redir_pc;
                r_instr_valid <= 1'b0;
                if (r_state != ST_DRAIN && w_req && !w_ack) begin
                    r_state <= ST_DRAIN;
                end
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc_out;
    assign pcplus2     = r_pc_out + c_step;
    assign op          = r_instr[c_op_msb:c_op_lsb];
    assign funct       = r_instr[c_funct_msb:c_funct_lsb];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch with a variable-latency imem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pcplus2;
    logic [3:0]  op;
    logic [2:0]  funct;

    logic [3:0]  lat;
    logic [3:0]  wcnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q[$];
    logic        prev_hold = 1'b0;
    logic [15:0] prev_addr = '0;

    always #5 clk = ~clk;

    instr_fetch_if mif ();

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem        (mif),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pcplus2     (pcplus2),
        .op          (op),
        .funct       (funct)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
    endfunction

    // imem answers lat cycles after the request first appears
    assign mif.imem_ack   = mif.imem_req && (wcnt == lat);
    assign mif.imem_rdata = mif.imem_ack ? mem_word(mif.imem_addr) : 16'hDEAD;

    always @(posedge clk) begin
        if (!reset_n || !mif.imem_req || mif.imem_ack) wcnt <= '0;
        else                                          wcnt <= wcnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (reset_n) begin
            if (prev_hold) chk("addr_stable", mif.imem_addr, prev_addr);
            if (instr_valid && !stall) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {15'd0, instr_valid}, 16'd0);
                end else begin
                    e = q.pop_front();
                    chk("pc_out",  pc_out, e.pc);
                    chk("instr",   instr, e.data);
                    chk("pcplus2", pcplus2, e.pc + 16'd2);
                    chk("op",      {12'd0, op}, {12'd0, e.data[15:12]});
                    chk("funct",   {13'd0, funct}, {13'd0, e.data[2:0]});
                end
            end
        end
        prev_hold = reset_n && mif.imem_req && !mif.imem_ack;
        prev_addr = mif.imem_addr;
    endtask

    task automatic cyc();
        #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        cyc();
        cyc();
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_instr", instr, 16'd0);
        chk("rst_pcout", pc_out, 16'd0);
        chk("rst_req",   {15'd0, mif.imem_req}, 16'd0);
        q.delete();
        reset_n = 1'b1;
    endtask

    task automatic expect_drained(input string tag);
        chk(tag, 16'(q.size()), 16'd0);
        q.delete();
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = 4'd0;

        // zero-wait memory, one instruction per cycle
        lat = 4'd0;
        do_reset();
        for (int i = 0; i < 8; i++) push(16'(2 * i));
        #1;
        chk("t1_req",  {15'd0, mif.imem_req}, 16'd1);
        chk("t1_addr", mif.imem_addr, 16'h0000);
        repeat (9) cyc();
        expect_drained("t1_done");

        // three-cycle memory wait
        lat = 4'd3;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'(2 * i));
        repeat (17) cyc();
        expect_drained("t2_done");

        // stall holds the slot and blocks new requests
        lat = 4'd0;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'(2 * i));
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_req",   {15'd0, mif.imem_req}, 16'd0);
            chk("t3_valid", {15'd0, instr_valid}, 16'd1);
            chk("t3_pcout", pc_out, 16'h0000);
            chk("t3_instr", instr, mem_word(16'h0000));
            cyc();
        end
        stall = 1'b0;
        repeat (4) cyc();
        expect_drained("t3_done");

        // redirect while waiting on imem drains the old request
        lat = 4'd3;
        do_reset();
        push(16'h0000);
        push(16'h0040);
        push(16'h0042);
        repeat (5) cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        cyc();
        redirect = 1'b0;
        repeat (2) cyc();
        #1;
        chk("t4_req",  {15'd0, mif.imem_req}, 16'd1);
        chk("t4_addr", mif.imem_addr, 16'h0040);
        repeat (10) cyc();
        expect_drained("t4_done");

        // redirect on the ack cycle, odd target has bit 0 cleared
        lat = 4'd0;
        do_reset();
        push(16'h0000);
        push(16'h0002);
        push(16'h0004);
        push(16'h0080);
        push(16'h0082);
        repeat (3) cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0081;
        cyc();
        redirect = 1'b0;
        #1;
        chk("t5_addr",  mif.imem_addr, 16'h0080);
        chk("t5_valid", {15'd0, instr_valid}, 16'd0);
        repeat (3) cyc();
        expect_drained("t5_done");

        // PC wraps from 0xFFFE to 0x0000
        lat = 4'd0;
        do_reset();
        push(16'hFFFC);
        push(16'hFFFE);
        push(16'h0000);
        push(16'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFC;
        cyc();
        redirect = 1'b0;
        repeat (5) cyc();
        expect_drained("t6_done");

        // reset asserted mid-WAIT
        lat = 4'd3;
        do_reset();
        push(16'h0000);
        repeat (5) cyc();
        reset_n = 1'b0;
        cyc();
        chk("t7_valid", {15'd0, instr_valid}, 16'd0);
        chk("t7_instr", instr, 16'd0);
        chk("t7_pcout", pc_out, 16'd0);
        chk("t7_req",   {15'd0, mif.imem_req}, 16'd0);
        reset_n = 1'b1;
        #1;
        chk("t7_refetch", mif.imem_addr, 16'h0000);
        cyc();
        expect_drained("t7_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
